// File: rtl/ram_arbiter.sv
// Round-robin N-master arbiter in front of a single-port RAM with registered RAM-side
// signals and a fixed-latency read return pipeline. Define RAM_ARBITER_PERF_COUNTERS_EN for perf counters.
module ram_arbiter #(
  parameter int NUM_MASTERS  = 2,
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  output logic [NUM_MASTERS-1:0]             m_ready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]  m_wdata,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_be,
  input  logic [NUM_MASTERS-1:0]             m_read_req,
  input  logic [NUM_MASTERS-1:0]             m_write_req,
  output logic [DATA_WIDTH-1:0]              m_rdata,
  output logic [NUM_MASTERS-1:0]             m_rdata_valid,
  output logic [ADDR_WIDTH-1:0]              ram_address,
  output logic [DATA_WIDTH/8-1:0]            ram_byteena,
  output logic [DATA_WIDTH-1:0]              ram_data,
  output logic                               ram_wren,
  input  logic [DATA_WIDTH-1:0]              ram_q,
  input  logic                               perf_clear,
  output logic [NUM_MASTERS*32-1:0]          perf_grant_count,
  output logic [NUM_MASTERS*32-1:0]          perf_wait_count
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int ID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } ret_t;

  logic [NUM_MASTERS-1:0] req;
  logic [ID_W-1:0]        last_grant;
  logic [ID_W-1:0]        grant_id;
  logic                   accept;
  logic                   win_write;
  logic                   win_read;
  ret_t [READ_LATENCY:0]  ret_pipe;

  assign req = m_read_req | m_write_req;

  // Handshake: m_ready[i] is combinational from the requests; a transfer is accepted on the
  // rising edge where m_ready[i] && req[i]. A waiting master holds its request fields stable.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    m_ready  = '0;
    grant_id = '0;
    idx      = 0;
    cand     = '0;
    // Scan from farthest to nearest so the master closest after last_grant wins.
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      idx = int'(last_grant) + 1 + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      cand = ID_W'(idx);
      if (req[cand]) grant_id = cand;
    end
    if (|req) m_ready[grant_id] = 1'b1;
  end

  assign accept    = |m_ready;
  assign win_write = m_write_req[grant_id];
  assign win_read  = m_read_req[grant_id] & ~win_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant  <= ID_W'(NUM_MASTERS - 1);
      ram_address <= '0;
      ram_byteena <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
    end else begin
      ram_wren <= accept & win_write;
      if (accept) begin
        last_grant  <= grant_id;
        ram_address <= m_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
        ram_byteena <= m_be[int'(grant_id)*BE_W +: BE_W];
        ram_data    <= m_wdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Entry k is live in cycle T+1+k after acceptance at T; the last entry lines up with ram_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ret_pipe <= '0;
    end else begin
      ret_pipe[0] <= {accept & win_read, grant_id};
      for (int k = 1; k <= READ_LATENCY; k++) ret_pipe[k] <= ret_pipe[k-1];
    end
  end

  always_comb begin
    m_rdata_valid = '0;
    if (ret_pipe[READ_LATENCY].valid) m_rdata_valid[ret_pipe[READ_LATENCY].id] = 1'b1;
  end

  assign m_rdata = ram_q;

`ifdef RAM_ARBITER_PERF_COUNTERS_EN
  logic [NUM_MASTERS-1:0][31:0] grant_cnt;
  logic [NUM_MASTERS-1:0][31:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt <= '0;
      wait_cnt  <= '0;
    end else if (perf_clear) begin
      grant_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (m_ready[i] && req[i] && grant_cnt[i] != 32'hFFFF_FFFF)
          grant_cnt[i] <= grant_cnt[i] + 32'd1;
        if (req[i] && !m_ready[i] && wait_cnt[i] != 32'hFFFF_FFFF)
          wait_cnt[i] <= wait_cnt[i] + 32'd1;
      end
    end
  end

  assign perf_grant_count = grant_cnt;
  assign perf_wait_count  = wait_cnt;
`else
  logic unused_perf_clear;
  assign unused_perf_clear = perf_clear;
  assign perf_grant_count  = '0;
  assign perf_wait_count   = '0;
`endif

`ifndef SYNTHESIS
  // A master must never raise read and write together; the write would win and the read is lost.
  rd_wr_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(|(m_read_req & m_write_req)));
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter (2 masters, 64-bit data, read latency 1) with a behavioural RAM.
module tb_ram_arbiter;
  localparam int NM = 2;
  localparam int AW = 14;
  localparam int DW = 64;
  localparam int BW = DW / 8;
`ifdef RAM_ARBITER_PERF_COUNTERS_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NM-1:0]     m_ready;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wdata;
  logic [NM*BW-1:0]  m_be;
  logic [NM-1:0]     m_read_req;
  logic [NM-1:0]     m_write_req;
  logic [DW-1:0]     m_rdata;
  logic [NM-1:0]     m_rdata_valid;
  logic [AW-1:0]     ram_address;
  logic [BW-1:0]     ram_byteena;
  logic [DW-1:0]     ram_data;
  logic              ram_wren;
  logic [DW-1:0]     ram_q;
  logic              perf_clear;
  logic [NM*32-1:0]  perf_grant_count;
  logic [NM*32-1:0]  perf_wait_count;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int n_vec = 0;
  int n_err = 0;

  localparam logic [DW-1:0] DATA_A = 64'hA0A0_0000_0000_0010;
  localparam logic [DW-1:0] DATA_B = 64'hB0B0_0000_0000_0020;

  ram_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_be(m_be), .m_read_req(m_read_req), .m_write_req(m_write_req), .m_rdata(m_rdata),
    .m_rdata_valid(m_rdata_valid), .ram_address(ram_address), .ram_byteena(ram_byteena),
    .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q), .perf_clear(perf_clear),
    .perf_grant_count(perf_grant_count), .perf_wait_count(perf_wait_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  // single-port RAM, one cycle read latency, byte-masked writes
  always @(posedge clk) begin
    if (ram_wren)
      for (int b = 0; b < BW; b++)
        if (ram_byteena[b]) mem[ram_address][b*8 +: 8] <= ram_data[b*8 +: 8];
    ram_q <= mem[ram_address];
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pexp(input int v);
    return PERF_ON ? 64'(v) : 64'h0;
  endfunction

  task automatic check_perf(input string tag, input int g0, input int w0, input int g1, input int w1);
    check({tag, "_grant0"}, 64'(perf_grant_count[31:0]),  pexp(g0));
    check({tag, "_wait0"},  64'(perf_wait_count[31:0]),   pexp(w0));
    check({tag, "_grant1"}, 64'(perf_grant_count[63:32]), pexp(g1));
    check({tag, "_wait1"},  64'(perf_wait_count[63:32]),  pexp(w1));
  endtask

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic drive(input int i, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
    m_read_req[i]        = rd;
    m_write_req[i]       = wr;
    m_addr[i*AW +: AW]   = a;
    m_wdata[i*DW +: DW]  = d;
    m_be[i*BW +: BW]     = be;
  endtask

  task automatic idle_all;
    for (int i = 0; i < NM; i++) drive(i, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    logic [63:0] exp_ready;
    logic [63:0] exp_addr;
    logic [63:0] exp_valid;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[14'h010] = DATA_A;
    mem[14'h020] = DATA_B;
    mem[14'h123] = 64'hDEAD_BEEF_CAFE_F00D;
    reset      = 1'b1;
    perf_clear = 1'b0;
    idle_all();

    // reset state
    tick; tick; sample;
    check("rst_address", 64'(ram_address), 64'h0);
    check("rst_byteena", 64'(ram_byteena), 64'h0);
    check("rst_data",    64'(ram_data),    64'h0);
    check("rst_wren",    64'(ram_wren),    64'h0);
    check("rst_valid",   64'(m_rdata_valid), 64'h0);
    check_perf("rst", 0, 0, 0, 0);
    tick; reset = 1'b0;
    sample;
    check("idle_ready", 64'(m_ready), 64'h0);

    // both masters read continuously for 6 cycles, then drop
    tick;
    drive(0, 1'b1, 1'b0, 14'h010, '0, '0);
    drive(1, 1'b1, 1'b0, 14'h020, '0, '0);
    for (int c = 0; c < 9; c++) begin
      if (c > 0) tick;
      if (c == 6) idle_all();
      sample;
      exp_ready = (c < 6) ? (((c % 2) == 1) ? 64'h2 : 64'h1) : 64'h0;
      exp_addr  = (c == 0) ? 64'h0 : (c <= 6) ? ((((c - 1) % 2) == 1) ? 64'h020 : 64'h010) : 64'h020;
      exp_valid = (c >= 2 && c <= 7) ? ((((c - 2) % 2) == 1) ? 64'h2 : 64'h1) : 64'h0;
      check($sformatf("rr_ready_c%0d", c),   64'(m_ready), exp_ready);
      check($sformatf("rr_address_c%0d", c), 64'(ram_address), exp_addr);
      check($sformatf("rr_wren_c%0d", c),    64'(ram_wren), 64'h0);
      check($sformatf("rr_valid_c%0d", c),   64'(m_rdata_valid), exp_valid);
      if (c == 0) begin
        check("pre_issue_data", 64'(ram_data), 64'h0);
        check("pre_issue_be",   64'(ram_byteena), 64'h0);
      end
      if (c >= 2 && c <= 7)
        check($sformatf("rr_rdata_c%0d", c), m_rdata, (((c - 2) % 2) == 1) ? DATA_B : DATA_A);
    end

    // single read from master 1 of preloaded word
    tick; drive(1, 1'b1, 1'b0, 14'h0123, '0, '0);
    sample; check("rd1_ready", 64'(m_ready), 64'h2);
    tick; idle_all();
    sample;
    check("rd1_address", 64'(ram_address), 64'h0123);
    check("rd1_wren",    64'(ram_wren), 64'h0);
    check("rd1_valid_t1", 64'(m_rdata_valid), 64'h0);
    tick; sample;
    check("rd1_valid_t2", 64'(m_rdata_valid), 64'h2);
    check("rd1_rdata",    m_rdata, 64'hDEAD_BEEF_CAFE_F00D);
    tick; sample;
    check("rd1_valid_t3", 64'(m_rdata_valid), 64'h0);

    // partial write by master 0 then read-after-write by master 1 at the top address
    tick; drive(0, 1'b0, 1'b1, 14'h3FFF, 64'h1122_3344_5566_7788, 8'h0F);
    sample; check("raw_wr_ready", 64'(m_ready), 64'h1);
    tick;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b1, 1'b0, 14'h3FFF, '0, 8'hFF);
    sample;
    check("raw_rd_ready", 64'(m_ready), 64'h2);
    check("raw_wren_t1",  64'(ram_wren), 64'h1);
    check("raw_address",  64'(ram_address), 64'h3FFF);
    check("raw_byteena",  64'(ram_byteena), 64'h0F);
    check("raw_data",     ram_data, 64'h1122_3344_5566_7788);
    tick; idle_all();
    sample;
    check("raw_wren_t2",    64'(ram_wren), 64'h0);
    check("raw_rd_address", 64'(ram_address), 64'h3FFF);
    check("raw_rd_byteena", 64'(ram_byteena), 64'hFF);
    check("raw_valid_t2",   64'(m_rdata_valid), 64'h0);
    tick; sample;
    check("raw_valid_t3", 64'(m_rdata_valid), 64'h2);
    check("raw_rdata",    m_rdata, 64'h0000_0000_5566_7788);
    tick; sample;
    check("raw_valid_t4", 64'(m_rdata_valid), 64'h0);

    // two reads in flight, reset before the second returns
    tick; drive(0, 1'b1, 1'b0, 14'h010, '0, '0);
    sample; check("flush_ready0", 64'(m_ready), 64'h1);
    tick;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b1, 1'b0, 14'h020, '0, '0);
    sample; check("flush_ready1", 64'(m_ready), 64'h2);
    tick; idle_all(); reset = 1'b1;
    sample;
    check("flush_valid_r0", 64'(m_rdata_valid), 64'h0);
    check("flush_address",  64'(ram_address), 64'h0);
    tick; sample;
    check("flush_valid_r1", 64'(m_rdata_valid), 64'h0);
    tick; reset = 1'b0;
    sample; check("flush_valid_rel0", 64'(m_rdata_valid), 64'h0);
    tick; sample; check("flush_valid_rel1", 64'(m_rdata_valid), 64'h0);
    tick; sample; check("flush_valid_rel2", 64'(m_rdata_valid), 64'h0);

    // contention for perf counters; arbitration restarts at master 0 after reset
    tick;
    drive(0, 1'b1, 1'b0, '0, '0, '0);
    drive(1, 1'b1, 1'b0, '0, '0, '0);
    sample;
    check("perf_ready_r0", 64'(m_ready), 64'h1);
    check_perf("perf_r0", 0, 0, 0, 0);
    tick; sample; check("perf_ready_r1", 64'(m_ready), 64'h2);
    tick; sample;
    check("perf_ready_r2", 64'(m_ready), 64'h1);
    check_perf("perf_r2", 1, 1, 1, 1);
    tick; drive(0, 1'b0, 1'b0, '0, '0, '0);
    sample; check("perf_ready_r3", 64'(m_ready), 64'h2);
    tick; idle_all(); drive(0, 1'b1, 1'b0, '0, '0, '0); perf_clear = 1'b1;
    sample;
    check("perf_ready_r4", 64'(m_ready), 64'h1);
    check_perf("perf_r4", 2, 1, 2, 2);
    tick; perf_clear = 1'b0; idle_all();
    sample; check_perf("perf_clr", 0, 0, 0, 0);
    tick; sample;
    check_perf("perf_hold", 0, 0, 0, 0);
    check("perf_rd_valid", 64'(m_rdata_valid), 64'h1);
    tick; sample;
    check("final_valid", 64'(m_rdata_valid), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
